// File: rtl/macc_lane_engine_pkg.sv
// Shared types and helpers for the lane-serial multiply-accumulate engine.
// Holds the one-hot state encoding, accumulator sizing and signed clamping.
package macc_lane_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_MAC  = 3'b010,
        ST_FIN  = 3'b100
    } state_e;

    // Upper bound on any accumulator width the helpers below must handle.
    localparam int unsigned MaxAccW = 192;

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned lanes);
        return 2 * data_w + $clog2(lanes) + 1;
    endfunction

    function automatic logic signed [MaxAccW-1:0] sat_signed(
        input logic signed [MaxAccW-1:0] value,
        input int unsigned               width
    );
        logic signed [MaxAccW-1:0] max_v;
        logic signed [MaxAccW-1:0] min_v;
        max_v = signed'((MaxAccW'(1) << (width - 1)) - MaxAccW'(1));
        min_v = ~max_v;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/macc_sat_reduce.sv
// Reduces the wide accumulator to a DATA_W result, either wrapped or clamped,
// and flags any value that does not fit in signed DATA_W.
module macc_sat_reduce
    import macc_lane_engine_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 67,
    parameter int unsigned SAT_EN = 0
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic        [DATA_W-1:0] result_o,
    output logic                     ovf_o
);

    logic signed [MaxAccW-1:0] acc_ext;
    logic signed [MaxAccW-1:0] sat_ext;

    always_comb begin
        acc_ext = MaxAccW'(acc_i);
        sat_ext = sat_signed(acc_ext, DATA_W);
        ovf_o   = (sat_ext != acc_ext);
        if (SAT_EN != 0) begin
            result_o = sat_ext[DATA_W-1:0];
        end else begin
            result_o = acc_ext[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/macc_lane_engine.sv
// Signed dot product of LANES operand pairs plus bias through one shared
// multiplier, behind an ap_start/ap_done/ap_idle/ap_ready block handshake.
module macc_lane_engine
    import macc_lane_engine_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned SAT_EN = 0
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    input  logic [LANES*DATA_W-1:0] a,
    input  logic [LANES*DATA_W-1:0] b,
    input  logic [DATA_W-1:0]       bias,
    input  logic                    mode,
    output logic [DATA_W-1:0]       o_acc,
    output logic                    o_acc_ap_vld,
    output logic                    o_ovf,
    output logic [DATA_W-1:0]       ap_return
);

    localparam int unsigned ACC_W = acc_width(DATA_W, LANES);
    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_e state_q, state_d;

    logic [LANES*DATA_W-1:0] a_q, a_d;
    logic [LANES*DATA_W-1:0] b_q, b_d;
    logic                    mode_q, mode_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        lane_q, lane_d;
    logic [DATA_W-1:0]       ret_q, ret_d;
    logic                    ovf_q, ovf_d;

    logic signed [DATA_W-1:0]   a_lane;
    logic signed [DATA_W-1:0]   b_lane;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_sum;
    logic                       last_lane;
    logic [DATA_W-1:0]          red_result;
    logic                       red_ovf;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ap_start) state_d = ST_MAC;
            ST_MAC:  if (last_lane) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ap_done      = (state_q == ST_FIN);
        ap_ready     = (state_q == ST_FIN);
        o_acc_ap_vld = (state_q == ST_FIN);
        ap_idle      = (state_q == ST_IDLE) && !ap_start;
        o_acc        = ret_q;
        ap_return    = ret_q;
        o_ovf        = ovf_q;
    end

    always_comb begin
        a_lane    = a_q[int'(lane_q)*DATA_W +: DATA_W];
        b_lane    = b_q[int'(lane_q)*DATA_W +: DATA_W];
        prod      = a_lane * b_lane;
        acc_sum   = mode_q ? (acc_q - ACC_W'(prod)) : (acc_q + ACC_W'(prod));
        last_lane = (lane_q == CNT_W'(LANES - 1));
    end

    // The reducer sees the sum including the final lane so the result is
    // registered on the same edge that enters FIN.
    macc_sat_reduce #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SAT_EN (SAT_EN)
    ) u_sat_reduce (
        .acc_i    (acc_sum),
        .result_o (red_result),
        .ovf_o    (red_ovf)
    );

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        acc_d  = acc_q;
        lane_d = lane_q;
        ret_d  = ret_q;
        ovf_d  = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    a_d    = a;
                    b_d    = b;
                    mode_d = mode;
                    acc_d  = ACC_W'(signed'(bias));
                    lane_d = '0;
                end
            end
            ST_MAC: begin
                acc_d  = acc_sum;
                lane_d = lane_q + CNT_W'(1);
                if (last_lane) begin
                    ret_d = red_result;
                    ovf_d = red_ovf;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            acc_q  <= '0;
            lane_q <= '0;
            ret_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            mode_q <= mode_d;
            acc_q  <= acc_d;
            lane_q <= lane_d;
            ret_q  <= ret_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule
